// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: PC register, combinational imem read, circular fetch queue to decode.
// Optional misaligned-redirect fault state enabled by `define FETCH_ALIGN_CHECK_EN.
module inst_fetch_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int RESET_PC    = 0,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic [DATA_WIDTH-1:0] inst_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  fetch_fault
);
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = PW + 1;

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;
  localparam logic [ADDR_WIDTH-1:0] BOOT_PC = ADDR_WIDTH'(RESET_PC);
  localparam state_t BOOT_STATE = (BOOT_PC[1:0] != 2'b00) ? FAULT : IDLE;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
  localparam logic [ADDR_WIDTH-1:0] BOOT_PC = ADDR_WIDTH'(RESET_PC) & ~(ADDR_WIDTH'(3));
  localparam state_t BOOT_STATE = IDLE;
`endif

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] inst_q [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q   [QUEUE_DEPTH];
  logic                  redirect_eff, push, pop;
  logic [ADDR_WIDTH-1:0] redirect_target;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;
  logic misaligned;
  // Once faulted, redirects are ignored until reset.
  assign redirect_eff    = redirect_valid && (state != FAULT);
  assign redirect_target = redirect_pc;
  assign misaligned      = (redirect_pc[1:0] != 2'b00);
  assign fetch_fault     = fault_q;
`else
  assign redirect_eff    = redirect_valid;
  assign redirect_target = redirect_pc & ~(ADDR_WIDTH'(3));
  assign fetch_fault     = 1'b0;
`endif

  assign inst_addr = {2'b00, pc[ADDR_WIDTH-1:2]};
  assign out_valid = (count != '0);
  assign out_inst  = inst_q[rd_ptr];
  assign out_pc    = pc_q[rd_ptr];
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign push      = (state == RUN) && !redirect_eff && ((count < CW'(QUEUE_DEPTH)) || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= BOOT_STATE;
      pc     <= BOOT_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q <= (BOOT_STATE == FAULT);
`endif
    end else begin
      case (state)
        IDLE:    if (fetch_en) state <= RUN;
        RUN:     if (!fetch_en) state <= IDLE;
        default: ;
      endcase

      if (redirect_eff) begin
        // Flush drops any same-cycle pop; decode treats that handshake as void.
        pc     <= redirect_target;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
        if (misaligned) begin
          state   <= FAULT;
          fault_q <= 1'b1;
        end
`endif
      end else begin
        if (push) begin
          inst_q[wr_ptr] <= inst_rdata;
          pc_q[wr_ptr]   <= pc;
          wr_ptr         <= wr_ptr + PW'(1);
          pc             <= pc + ADDR_WIDTH'(4);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed-vector bench for inst_fetch_unit with a combinational 64-word instruction memory.
module tb_inst_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        fetch_fault;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mem [64];

  always #5 clk = ~clk;
  assign inst_rdata = mem[inst_addr[5:0]];

  inst_fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(0), .QUEUE_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .fetch_fault(fetch_fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid); end
    vectors++; if (inst_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr got %h want 0", inst_addr); end
    vectors++; if (out_inst !== 32'h0) begin miscompares++; $display("FAIL reset_inst got %h want 0", out_inst); end
    vectors++; if (out_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want 0", out_pc); end
    vectors++; if (fetch_fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault got %b want 0", fetch_fault); end
  endtask

  task automatic test_basic_fetch();
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b1;
    vectors++; if (inst_addr !== 32'd0) begin miscompares++; $display("FAIL basic_addr0 got %h want 0", inst_addr); end
    step();
    vectors++; if (out_valid !== 1'b0 || inst_addr !== 32'd0) begin miscompares++; $display("FAIL basic_c1 got v=%b a=%h want v=0 a=0", out_valid, inst_addr); end
    step();
    vectors++; if (out_valid !== 1'b1 || out_inst !== 32'h34D78131 || out_pc !== 32'h0 || inst_addr !== 32'd1) begin
      miscompares++; $display("FAIL basic_c2 got v=%b i=%h pc=%h a=%h want 1 34d78131 0 1", out_valid, out_inst, out_pc, inst_addr); end
    step();
    vectors++; if (out_valid !== 1'b1 || out_inst !== 32'h0AC510D1 || out_pc !== 32'h4 || inst_addr !== 32'd2) begin
      miscompares++; $display("FAIL basic_c3 got v=%b i=%h pc=%h a=%h want 1 0ac510d1 4 2", out_valid, out_inst, out_pc, inst_addr); end
    step();
    vectors++; if (out_inst !== 32'hC0DE0002 || out_pc !== 32'h8 || inst_addr !== 32'd3) begin
      miscompares++; $display("FAIL basic_c4 got i=%h pc=%h a=%h want c0de0002 8 3", out_inst, out_pc, inst_addr); end
  endtask

  task automatic test_backpressure();
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    repeat (4) step();
    for (int k = 0; k < 2; k++) begin
      vectors++; if (inst_addr !== 32'd2 || out_valid !== 1'b1 || out_inst !== 32'h34D78131 || out_pc !== 32'h0) begin
        miscompares++; $display("FAIL bp_hold%0d got a=%h v=%b i=%h pc=%h want 2 1 34d78131 0", k, inst_addr, out_valid, out_inst, out_pc); end
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      vectors++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_inst !== mem[k]) begin
        miscompares++; $display("FAIL bp_drain%0d got v=%b pc=%h i=%h want 1 %h %h", k, out_valid, out_pc, out_inst, 32'(4 * k), mem[k]); end
      step();
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    repeat (4) step();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0 || inst_addr !== 32'h10) begin
      miscompares++; $display("FAIL redir_flush got v=%b a=%h want 0 10", out_valid, inst_addr); end
    step();
    vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_inst !== 32'hC0DE0010) begin
      miscompares++; $display("FAIL redir_first got v=%b pc=%h i=%h want 1 40 c0de0010", out_valid, out_pc, out_inst); end
    out_ready = 1'b1;
    step();
    vectors++; if (out_pc !== 32'h44 || out_inst !== 32'hC0DE0011) begin
      miscompares++; $display("FAIL redir_next got pc=%h i=%h want 44 c0de0011", out_pc, out_inst); end
  endtask

  task automatic test_redirect_pop();
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b1;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0 || inst_addr !== 32'h20) begin
      miscompares++; $display("FAIL rpop_flush got v=%b a=%h want 0 20", out_valid, inst_addr); end
    step();
    for (int k = 0; k < 4; k++) begin
      vectors++; if (out_valid !== 1'b1 || out_pc !== 32'(32'h80 + 4 * k) || out_inst !== mem[32 + k]) begin
        miscompares++; $display("FAIL rpop_seq%0d got v=%b pc=%h i=%h want 1 %h %h", k, out_valid, out_pc, out_inst, 32'(32'h80 + 4 * k), mem[32 + k]); end
      step();
    end
  endtask

  task automatic test_idle_redirect();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step();
    redirect_valid = 1'b0;
    step(); step();
    vectors++; if (inst_addr !== 32'h8 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL idle_redir got a=%h v=%b want 8 0", inst_addr, out_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    vectors++; if (out_pc !== 32'hFFFF_FFFC || out_inst !== mem[63] || inst_addr !== 32'h0) begin
      miscompares++; $display("FAIL wrap got pc=%h i=%h a=%h want fffffffc %h 0", out_pc, out_inst, inst_addr, mem[63]); end
    step();
    vectors++; if (out_pc !== 32'h0 || out_inst !== 32'h34D78131) begin
      miscompares++; $display("FAIL wrap_next got pc=%h i=%h want 0 34d78131", out_pc, out_inst); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    repeat (5) step();
    vectors++; if (out_valid !== 1'b1 || inst_addr !== 32'd2) begin
      miscompares++; $display("FAIL mid_full got v=%b a=%h want 1 2", out_valid, inst_addr); end
    rst = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0 || inst_addr !== 32'h0) begin
      miscompares++; $display("FAIL mid_async got v=%b a=%h want 0 0", out_valid, inst_addr); end
    step();
    rst = 1'b0; out_ready = 1'b1;
    step(); step();
    vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h34D78131) begin
      miscompares++; $display("FAIL mid_resume got v=%b pc=%h i=%h want 1 0 34d78131", out_valid, out_pc, out_inst); end
  endtask

  task automatic test_align();
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b1;
    repeat (3) step();
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    vectors++; if (fetch_fault !== 1'b1 || out_valid !== 1'b0 || inst_addr !== 32'h10) begin
      miscompares++; $display("FAIL align_fault got f=%b v=%b a=%h want 1 0 10", fetch_fault, out_valid, inst_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    step(); step();
    vectors++; if (fetch_fault !== 1'b1 || out_valid !== 1'b0 || inst_addr !== 32'h10) begin
      miscompares++; $display("FAIL align_sticky got f=%b v=%b a=%h want 1 0 10", fetch_fault, out_valid, inst_addr); end
`else
    vectors++; if (fetch_fault !== 1'b0 || out_valid !== 1'b0 || inst_addr !== 32'h10) begin
      miscompares++; $display("FAIL align_mask got f=%b v=%b a=%h want 0 0 10", fetch_fault, out_valid, inst_addr); end
    step();
    vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin
      miscompares++; $display("FAIL align_resume got v=%b pc=%h want 1 40", out_valid, out_pc); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE0000 | 32'(i);
    mem[0] = 32'h34D78131;
    mem[1] = 32'h0AC510D1;
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_redirect_full();
    test_redirect_pop();
    test_idle_redirect();
    test_wrap();
    test_rst_mid();
    test_align();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface.
- Owns the program counter and drives a word index onto the memory's combinational read port.
- Captures the returned instruction word together with its PC into a small circular queue, which feeds decode over a valid/ready handshake.
- Supports redirect (branch/jump) with queue flush, and start/stop under fetch_en.

Parameters:
- DATA_WIDTH, 32, instruction word width
- ADDR_WIDTH, 32, PC and inst_addr width
- RESET_PC, 0, byte address loaded into the PC at reset
- QUEUE_DEPTH, 2, fetch queue entries; power of two, >= 2

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- fetch_en  input  1  1 = fetch; 0 = hold PC, stop pushing
- redirect_valid  input  1  load new PC and flush queue
- redirect_pc  input  ADDR_WIDTH  redirect target byte address
- inst_addr  output  ADDR_WIDTH  word index to instruction memory
- inst_rdata  input  DATA_WIDTH  word returned combinationally, same cycle
- out_valid  output  1  queue head valid
- out_ready  input  1  decode accepts head
- out_inst  output  DATA_WIDTH  head instruction
- out_pc  output  ADDR_WIDTH  head byte PC
- fetch_fault  output  1  sticky misalignment fault (only with the optional feature; tied 0 otherwise)

Behaviour:
- Interface: one clock, clk; asynchronous active-high reset, rst.
- Reset values (async, any time, including mid-operation):
  - pc = RESET_PC, state = IDLE
  - queue empty: count = 0, rd_ptr = wr_ptr = 0
  - out_valid = 0, out_inst = 0, out_pc = 0, fetch_fault = 0
  - inst_addr = RESET_PC >> 2
- Address: inst_addr = {2'b00, pc[ADDR_WIDTH-1:2]}, combinational from the pc register. pc advances by 4 modulo 2^ADDR_WIDTH; the all-ones value wraps to 0.
- States:
  - IDLE -> RUN when fetch_en = 1.
  - RUN -> IDLE when fetch_en = 0. The queue is retained and may keep draining.
  - FAULT exists only with the optional feature.
- push condition: state = RUN, no redirect this cycle, and (count < QUEUE_DEPTH or a pop happens this cycle).
- On push, entry[wr_ptr] = {pc, inst_rdata}, wr_ptr++, and pc += 4.
- Latency: the word at pc is visible on out_inst the cycle after its push. At sustained rate, one instruction per cycle when out_ready = 1.
- pop condition: out_valid = 1 and out_ready = 1; rd_ptr++.
- Same-cycle push and pop: count is unchanged. This is legal when full.
- Outputs: out_valid = (count != 0). out_inst and out_pc come from entry[rd_ptr] and must hold stable while out_valid = 1 and out_ready = 0.
- Full: no push; pc and inst_addr hold.
- Empty: out_valid = 0; out_inst/out_pc contents are don't-care.
- Redirect has highest priority:
  - pc <= redirect_pc; count, rd_ptr and wr_ptr are cleared.
  - No push this cycle. Any pop that cycle is discarded, and decode must treat the handshake as void.
  - Accepted in IDLE and RUN. In IDLE it only updates pc.
  - First post-redirect push is in the next cycle if state = RUN.
- Pointers wrap modulo QUEUE_DEPTH; count ranges 0..QUEUE_DEPTH.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0] != 0 enters FAULT. Queue is flushed, pc <= redirect_pc, fetch_fault = 1 (sticky).
  - FAULT accepts no pushes and no further redirects; out_valid = 0. Only rst exits FAULT.
  - RESET_PC[1:0] != 0 enters FAULT directly out of reset.
- Undefined:
  - redirect_pc[1:0] and RESET_PC[1:0] are forced to 0 on load; no FAULT state.
  - fetch_fault is tied to 0.

Test Plan:
- Reset, RESET_PC = 0, memory[0] = 32'h34D78131, memory[1] = 32'h0AC510D1, fetch_en = 1, out_ready = 1 -> inst_addr sequence 0,1,2...; cycle 2 gives out_inst 34D78131/out_pc 0, cycle 3 gives 0AC510D1/out_pc 4.
- out_ready = 0 with fetch_en = 1 -> after 2 pushes, count = 2 and inst_addr holds at 2; out_inst stays 34D78131; raising out_ready resumes at one per cycle with no loss or duplication.
- Redirect to 0x40 while queue holds 2 entries -> next cycle out_valid = 0 and inst_addr = 0x10; following cycle out_pc = 0x40.
- Redirect and pop in the same cycle -> popped entry discarded, queue empty, no stale PC ever reappears.
- Assert rst mid-run with queue full -> immediately out_valid = 0 and inst_addr = RESET_PC >> 2; normal fetch resumes after release.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x42 -> fetch_fault = 1 sticky, out_valid = 0, later redirects ignored until rst. Without the macro, fetch resumes from 0x40.
